// File: rtl/pid_sequencer.sv
// Time-multiplexed PID sequencer: one shared 8x10 signed multiplier walks the
// P, I and D terms over five busy cycles, triggered by a period timer or start.
`timescale 1ns/1ps
module pid_sequencer #(
  parameter logic [7:0] KP_RST = 8'd2,
  parameter logic [7:0] KI_RST = 8'd0,
  parameter logic [7:0] KD_RST = 8'd0,
  parameter int         PER_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       start,
  input  logic       clr_int,
  input  logic [7:0] setpoint,
  input  logic [7:0] feedback,
  output logic       busy,
  output logic       done,
  output logic [7:0] control_signal,
  output logic       sat_flag,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_MUL_P, S_MUL_I, S_MUL_D, S_SUM
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic [PER_W-1:0]   period_q, period_d, cnt_q, cnt_d;
  logic signed [17:0] integral_q, integral_d;
  logic signed [8:0]  prev_err_q, prev_err_d;
  logic [7:0]         ctrl_q, ctrl_d;
  logic               sat_q, sat_d, done_q, done_d, overrun_q, overrun_d;
  logic               clr_pend_q, clr_pend_d;

  logic signed [8:0]  err_q, err_d;
  logic [7:0]         kp_s_q, kp_s_d, ki_s_q, ki_s_d, kd_s_q, kd_s_d;
  logic signed [17:0] p_q, p_d, d_q, d_d;

  logic               tick, trigger, clr_now;
  logic [7:0]         mul_gain;
  logic signed [9:0]  mul_opnd, diff;
  logic signed [17:0] mul_a, mul_b, prod;
  logic signed [19:0] sum;
  logic [8:0]         clamped;

  function automatic logic signed [17:0] sat18(input logic signed [18:0] x);
    if (x[18] != x[17]) return x[18] ? 18'sh20000 : 18'sh1FFFF;
    return x[17:0];
  endfunction

  // {sat, value}: negative sums floor at 0, anything above 255 ceils at 255
  function automatic logic [8:0] clamp8(input logic signed [19:0] s);
    if (s[19])          return {1'b1, 8'd0};
    else if (|s[18:8])  return {1'b1, 8'd255};
    return {1'b0, s[7:0]};
  endfunction

  assign tick    = (period_q != '0) && (cnt_q == period_q - PER_W'(1));
  assign trigger = start | tick;
  assign diff    = {err_q[8], err_q} - {prev_err_q[8], prev_err_q};

  always_comb begin
    mul_gain = kp_s_q;
    mul_opnd = {err_q[8], err_q};
    case (state_q)
      S_MUL_I: mul_gain = ki_s_q;
      S_MUL_D: begin mul_gain = kd_s_q; mul_opnd = diff; end
      default: ;
    endcase
    mul_a = {10'd0, mul_gain};
    mul_b = {{8{mul_opnd[9]}}, mul_opnd};
    prod  = mul_a * mul_b;
    sum   = {{2{p_q[17]}}, p_q} + {{2{integral_q[17]}}, integral_q} + {{2{d_q[17]}}, d_q};
    clamped = clamp8(sum);
  end

  always_comb begin
    state_d    = state_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    kd_d       = kd_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    integral_d = integral_q;
    prev_err_d = prev_err_q;
    ctrl_d     = ctrl_q;
    sat_d      = sat_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    clr_pend_d = clr_pend_q;
    err_d      = err_q;
    kp_s_d     = kp_s_q;
    ki_s_d     = ki_s_q;
    kd_s_d     = kd_s_q;
    p_d        = p_q;
    d_d        = d_q;
    clr_now    = clr_pend_q | clr_int;

    if (period_q != '0) cnt_d = tick ? '0 : cnt_q + PER_W'(1);
    if (state_q != S_IDLE && trigger) overrun_d = 1'b1;

    if (cfg_we) begin
      case (cfg_addr)
        2'd0: kp_d = cfg_wdata;
        2'd1: ki_d = cfg_wdata;
        2'd2: kd_d = cfg_wdata;
        default: begin
          period_d  = PER_W'(cfg_wdata);
          cnt_d     = '0;
          overrun_d = 1'b0;
        end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (clr_int) begin
          integral_d = '0;
          prev_err_d = '0;
        end
        if (trigger) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        err_d      = $signed({1'b0, setpoint}) - $signed({1'b0, feedback});
        kp_s_d     = kp_q;
        ki_s_d     = ki_q;
        kd_s_d     = kd_q;
        clr_pend_d = clr_pend_q | clr_int;
        state_d    = S_MUL_P;
      end
      S_MUL_P: begin
        p_d        = prod;
        clr_pend_d = clr_now;
        state_d    = S_MUL_I;
      end
      S_MUL_I: begin
        integral_d = sat18({integral_q[17], integral_q} + {prod[17], prod});
        clr_pend_d = clr_now;
        state_d    = S_MUL_D;
      end
      S_MUL_D: begin
        d_d        = prod;
        clr_pend_d = clr_now;
        state_d    = S_SUM;
      end
      S_SUM: begin
        ctrl_d     = clamped[7:0];
        sat_d      = clamped[8];
        done_d     = 1'b1;
        prev_err_d = clr_now ? 9'sd0 : err_q;
        if (clr_now) integral_d = '0;
        clr_pend_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      kp_q       <= KP_RST;
      ki_q       <= KI_RST;
      kd_q       <= KD_RST;
      period_q   <= '0;
      cnt_q      <= '0;
      integral_q <= '0;
      prev_err_q <= '0;
      ctrl_q     <= '0;
      sat_q      <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      kd_q       <= kd_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      integral_q <= integral_d;
      prev_err_q <= prev_err_d;
      ctrl_q     <= ctrl_d;
      sat_q      <= sat_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // Datapath scratch is always rewritten before use inside a sequence
  always_ff @(posedge clk) begin
    err_q  <= err_d;
    kp_s_q <= kp_s_d;
    ki_s_q <= ki_s_d;
    kd_s_q <= kd_s_d;
    p_q    <= p_d;
    d_q    <= d_d;
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign control_signal = ctrl_q;
  assign sat_flag       = sat_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_pid_sequencer.sv
// Self-checking bench for pid_sequencer: directed scenarios plus randomized
// samples compared against an arithmetic PID model.
`timescale 1ns/1ps
module tb_pid_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_wdata = 8'd0;
  logic       start = 1'b0;
  logic       clr_int = 1'b0;
  logic [7:0] setpoint = 8'd0;
  logic [7:0] feedback = 8'd0;
  logic       busy, done, sat_flag, overrun;
  logic [7:0] control_signal;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int m_kp, m_ki, m_kd, m_int, m_prev;

  pid_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .clr_int(clr_int),
    .setpoint(setpoint), .feedback(feedback), .busy(busy), .done(done),
    .control_signal(control_signal), .sat_flag(sat_flag), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic model_reset();
    m_kp = 2; m_ki = 0; m_kd = 0; m_int = 0; m_prev = 0;
  endtask

  task automatic model_cfg(input int a, input int v);
    if (a == 0) m_kp = v;
    else if (a == 1) m_ki = v;
    else if (a == 2) m_kd = v;
  endtask

  task automatic model_sample(input int sp, input int fb, output int o, output int s);
    int e, sm;
    e = sp - fb;
    m_int = m_int + m_ki * e;
    if (m_int > 131071) m_int = 131071;
    if (m_int < -131072) m_int = -131072;
    sm = m_kp * e + m_int + m_kd * (e - m_prev);
    m_prev = e;
    if (sm < 0) begin o = 0; s = 1; end
    else if (sm > 255) begin o = 255; s = 1; end
    else begin o = sm; s = 0; end
  endtask

  task automatic cfg_write(input int a, input int v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_wdata = 8'(v);
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(a, v);
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr_int = 1'b1;
    @(negedge clk); clr_int = 1'b0;
    m_int = 0; m_prev = 0;
  endtask

  task automatic do_sample(input int sp, input int fb, input bit mcfg, input int ma,
                           input int md, input bit mclr);
    int eo, es, lat;
    bit got;
    setpoint = 8'(sp); feedback = 8'(fb); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start", int'(busy), 1);
    model_sample(sp, fb, eo, es);
    if (mcfg) model_cfg(ma, md);
    if (mclr) begin m_int = 0; m_prev = 0; end
    got = 1'b0; lat = 0;
    for (int n = 1; n <= 10 && !got; n++) begin
      cfg_we = mcfg && (n == 2); cfg_addr = 2'(ma); cfg_wdata = 8'(md);
      clr_int = mclr && (n == 2);
      @(negedge clk);
      if (done) begin got = 1'b1; lat = n; end
    end
    cfg_we = 1'b0; clr_int = 1'b0;
    check("done_latency", lat, 5);
    check("ctrl", int'(control_signal), eo);
    check("sat", int'(sat_flag), es);
    check("busy_end", int'(busy), 0);
    @(negedge clk);
    check("done_pulse", int'(done), 0);
  endtask

  task automatic wait_done(output int c);
    int eo, es;
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("timer_done_seen", int'(got), 1);
    c = cyc;
    if (got) begin
      model_sample(int'(setpoint), int'(feedback), eo, es);
      check("timer_ctrl", int'(control_signal), eo);
    end
  endtask

  initial begin
    int c1, c2, c3, c4, c5, c6, w;
    bit any_done;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ctrl", int'(control_signal), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_done", int'(done), 0);
    check("rst_sat", int'(sat_flag), 0);
    check("rst_overrun", int'(overrun), 0);

    do_sample(100, 60, 0, 0, 0, 0);
    do_sample(10, 50, 0, 0, 0, 0);
    cfg_write(0, 4);
    do_sample(200, 100, 0, 0, 0, 0);

    cfg_write(0, 0); cfg_write(1, 1);
    repeat (3) do_sample(20, 10, 0, 0, 0, 0);
    clr_pulse();
    do_sample(20, 10, 0, 0, 0, 0);
    cfg_write(1, 255); clr_pulse();
    repeat (3) do_sample(255, 0, 0, 0, 0, 0);

    cfg_write(1, 0); cfg_write(2, 3); clr_pulse();
    do_sample(20, 10, 0, 0, 0, 0);
    do_sample(40, 10, 0, 0, 0, 0);
    do_sample(20, 10, 0, 0, 0, 0);
    check("no_overrun", int'(overrun), 0);

    cfg_write(0, 2); cfg_write(2, 0); clr_pulse();
    setpoint = 8'd50; feedback = 8'd20;
    cfg_write(3, 8);
    wait_done(c1);
    wait_done(c2);
    check("per8_interval", c2 - c1, 8);
    for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("overrun_set", int'(overrun), 1);
    wait_done(c3);
    check("per8_no_extra", c3 - c2, 8);
    cfg_write(3, 8);
    w = cyc;
    check("overrun_clr", int'(overrun), 0);
    wait_done(c4);
    check("per8_restart", c4 - w, 13);
    cfg_write(3, 4);
    wait_done(c5);
    wait_done(c6);
    check("per4_overrun", int'(overrun), 1);
    check("per4_min_interval", int'(c6 - c5 >= 6), 1);
    cfg_write(3, 0);
    check("per0_overrun_clr", int'(overrun), 0);
    any_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) any_done = 1'b1;
    end
    check("per0_idle", int'(any_done), 0);

    do_sample(100, 60, 1, 0, 3, 0);
    do_sample(100, 60, 0, 0, 0, 0);

    cfg_write(0, 0); cfg_write(1, 1); clr_pulse();
    do_sample(20, 10, 0, 0, 0, 0);
    do_sample(20, 10, 0, 0, 0, 0);
    do_sample(20, 10, 0, 0, 0, 1);
    do_sample(20, 10, 0, 0, 0, 0);
    check("clr_busy_next", int'(control_signal), 10);

    cfg_write(1, 3);
    setpoint = 8'd100; feedback = 8'd60; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", int'(control_signal), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_sat", int'(sat_flag), 0);
    any_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    check("abort_no_done", int'(any_done), 0);
    model_reset();
    do_sample(100, 60, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) cfg_write($urandom_range(0, 2), $urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) clr_pulse();
      do_sample($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3) == 0,
                $urandom_range(0, 2), $urandom_range(0, 255), $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
